// File: rtl/player_ctrl_pkg.sv
// Shared types and helpers for the player speed-ramp controller.
// State and direction codes match the debug bus and the player_speed switch bus.
package player_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECAY  = 3'd3,
    BRAKE  = 3'd4,
    FROZEN = 3'd5
  } ramp_state_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Level n lights bit n-1; level 0 is all zeros.
  function automatic logic [5:0] level_to_onehot(input logic [2:0] level);
    logic [5:0] onehot;
    onehot = '0;
    if (level != '0) onehot = 6'b000001 << (level - 3'd1);
    return onehot;
  endfunction

endpackage

// File: rtl/player_speed_ramp_ctrl_frame_divider.sv
// Saturating frame-tick counter; hit flags the tick that brings the count to threshold.
module frame_divider #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock_100mhz,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] threshold,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  assign hit = frame_tick && (({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, threshold});

  always_ff @(posedge clock_100mhz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (frame_tick && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_speed_ramp_ctrl.sv
// Direction-button driven speed ramp: accelerates while held, decays on release,
// brakes to zero before a reversal. speed_sel feeds player_speed's sw input.
module player_speed_ramp_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_FRAMES  = 8,
  parameter int unsigned DECAY_FRAMES = 4,
  parameter int unsigned BRAKE_FRAMES = 1,
  parameter int unsigned MAX_LEVEL    = 6
) (
  input  logic       clock_100mhz,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [5:0] speed_sel,
  output logic [1:0] dir,
  output logic       moving,
  output logic [2:0] ramp_state
);

  localparam int unsigned MAX_RD     = (RAMP_FRAMES > DECAY_FRAMES) ? RAMP_FRAMES : DECAY_FRAMES;
  localparam int unsigned MAX_FRAMES = (MAX_RD > BRAKE_FRAMES) ? MAX_RD : BRAKE_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam logic [CNT_W-1:0] RAMP_T  = CNT_W'(RAMP_FRAMES);
  localparam logic [CNT_W-1:0] DECAY_T = CNT_W'(DECAY_FRAMES);
  localparam logic [CNT_W-1:0] BRAKE_T = CNT_W'(BRAKE_FRAMES);
  localparam logic [2:0]       LVL_MAX = 3'(MAX_LEVEL);

  if (RAMP_FRAMES == 0 || DECAY_FRAMES == 0 || BRAKE_FRAMES == 0) begin : g_bad_frames
    $fatal(1, "player_speed_ramp_ctrl: *_FRAMES parameters must be non-zero");
  end
  if (MAX_LEVEL < 1 || MAX_LEVEL > 6) begin : g_bad_level
    $fatal(1, "player_speed_ramp_ctrl: MAX_LEVEL must be in 1..6");
  end

  ramp_state_e      state, state_next;
  logic [2:0]       level, level_next;
  logic [1:0]       dir_next, req_dir;
  logic [5:0]       speed_sel_next;
  logic             moving_next, pressed, hit, cnt_clear;
  logic [CNT_W-1:0] threshold;

  assign pressed = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    req_dir = DIR_RIGHT;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
  end

  // Restarting from level 0 after a brake steps to level 1 on the very next tick.
  always_comb begin
    threshold = RAMP_T;
    unique case (state)
      ACCEL:   threshold = (level == '0) ? CNT_W'(1) : RAMP_T;
      DECAY:   threshold = DECAY_T;
      BRAKE:   threshold = BRAKE_T;
      default: threshold = RAMP_T;
    endcase
  end

  frame_divider #(.CNT_W(CNT_W)) u_frame_divider (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .clear        (cnt_clear),
    .frame_tick   (frame_tick),
    .threshold    (threshold),
    .hit          (hit)
  );

  assign cnt_clear = (state_next != state) || (level_next != level) || !game_active;

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      dir       <= DIR_UP;
      speed_sel <= '0;
      moving    <= 1'b0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      dir       <= dir_next;
      speed_sel <= speed_sel_next;
      moving    <= moving_next;
    end
  end

  // Button-driven transitions take precedence over a coincident threshold tick.
  always_comb begin
    state_next = state;
    level_next = level;
    dir_next   = dir;
    if (!game_active) begin
      state_next = FROZEN;
      level_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          level_next = '0;
          if (pressed) begin
            state_next = ACCEL;
            dir_next   = req_dir;
            level_next = 3'd1;
          end
        end
        ACCEL: begin
          if (!pressed)                  state_next = DECAY;
          else if (req_dir != dir)       state_next = BRAKE;
          else if (level >= LVL_MAX)     state_next = CRUISE;
          else if (hit) begin
            level_next = level + 3'd1;
            if (level + 3'd1 == LVL_MAX) state_next = CRUISE;
          end
        end
        CRUISE: begin
          if (!pressed)                  state_next = DECAY;
          else if (req_dir != dir)       state_next = BRAKE;
        end
        DECAY: begin
          if (pressed && req_dir == dir) state_next = ACCEL;
          else if (pressed)              state_next = BRAKE;
          else if (level == '0)          state_next = IDLE;
          else if (hit) begin
            level_next = level - 3'd1;
            if (level == 3'd1)           state_next = IDLE;
          end
        end
        BRAKE: begin
          if (level == '0 || (hit && level == 3'd1)) begin
            level_next = '0;
            if (pressed) begin
              state_next = ACCEL;
              dir_next   = req_dir;
            end else begin
              state_next = IDLE;
            end
          end else if (!pressed) begin
            state_next = DECAY;
          end else if (hit) begin
            level_next = level - 3'd1;
          end
        end
        FROZEN: begin
          level_next = '0;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          level_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    speed_sel_next = level_to_onehot(level_next);
    moving_next    = (level_next != '0);
  end

  assign ramp_state = state;

endmodule

// File: tb/tb_player_speed_ramp_ctrl.sv
// Bench for player_speed_ramp_ctrl: vector table for reset/priority/collision cases,
// then ramp, decay, reversal and freeze sequences checked through a scoreboard queue.
module tb_player_speed_ramp_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_CRUISE = 3'd2;
  localparam logic [2:0] S_DECAY  = 3'd3;
  localparam logic [2:0] S_BRAKE  = 3'd4;
  localparam logic [2:0] S_FROZEN = 3'd5;
  localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;
  localparam logic [3:0] B_NONE = 4'b0000, B_UP = 4'b1000, B_DOWN = 4'b0100;
  localparam logic [3:0] B_LEFT = 4'b0010, B_RIGHT = 4'b0001;
  localparam int NVEC = 21;

  logic clock_100mhz = 1'b0;
  logic reset, frame_tick, game_active;
  logic btn_up, btn_down, btn_left, btn_right;
  logic [5:0] speed_sel;
  logic [1:0] dir;
  logic       moving;
  logic [2:0] ramp_state;

  always #5 clock_100mhz = ~clock_100mhz;

  player_speed_ramp_ctrl #(
    .RAMP_FRAMES  (8),
    .DECAY_FRAMES (4),
    .BRAKE_FRAMES (1),
    .MAX_LEVEL    (6)
  ) dut (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .game_active  (game_active),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .speed_sel    (speed_sel),
    .dir          (dir),
    .moving       (moving),
    .ramp_state   (ramp_state)
  );

  typedef struct packed {
    logic [5:0] sel;
    logic [1:0] dir;
    logic       mov;
    logic [2:0] st;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       ga;
    logic       tick;
    logic [3:0] btn;
    int         lvl;
    logic [1:0] dir;
    logic [2:0] st;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   passes = 0;

  function automatic exp_t mk_exp(input int lvl, input logic [1:0] d, input logic [2:0] st);
    exp_t e;
    e.sel = (lvl == 0) ? 6'd0 : 6'(1 << (lvl - 1));
    e.dir = d;
    e.mov = (lvl != 0);
    e.st  = st;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic rst, input logic ga, input logic tick,
                                  input logic [3:0] btn, input int lvl,
                                  input logic [1:0] d, input logic [2:0] st);
    vec_t v;
    v.rst = rst; v.ga = ga; v.tick = tick; v.btn = btn;
    v.lvl = lvl; v.dir = d; v.st = st;
    return v;
  endfunction

  // Drive one cycle, queue its expected result, and compare after the edge.
  task automatic cyc(input string name, input logic rst, input logic ga, input logic tick,
                     input logic [3:0] btn, input int lvl, input logic [1:0] d,
                     input logic [2:0] st);
    exp_t got, want;
    reset = rst;
    game_active = ga;
    frame_tick = tick;
    {btn_up, btn_down, btn_left, btn_right} = btn;
    sb_q.push_back(mk_exp(lvl, d, st));
    @(posedge clock_100mhz);
    #1;
    got = {speed_sel, dir, moving, ramp_state};
    want = sb_q.pop_front();
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got sel=%b dir=%b moving=%b state=%0d, expected sel=%b dir=%b moving=%b state=%0d",
                  name, got.sel, got.dir, got.mov, got.st, want.sel, want.dir, want.mov, want.st);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lvl;
    // reset with btn_up held, release, decay of level 1, priority and tick collision
    vecs[0]  = mk_vec(1, 1, 0, B_UP,           0, D_UP, S_IDLE);
    vecs[1]  = mk_vec(1, 1, 0, B_UP,           0, D_UP, S_IDLE);
    vecs[2]  = mk_vec(0, 1, 0, B_UP,           1, D_UP, S_ACCEL);
    vecs[3]  = mk_vec(0, 1, 0, B_NONE,         1, D_UP, S_DECAY);
    vecs[4]  = mk_vec(0, 1, 0, B_NONE,         1, D_UP, S_DECAY);
    vecs[5]  = mk_vec(0, 1, 1, B_NONE,         1, D_UP, S_DECAY);
    vecs[6]  = mk_vec(0, 1, 1, B_NONE,         1, D_UP, S_DECAY);
    vecs[7]  = mk_vec(0, 1, 1, B_NONE,         1, D_UP, S_DECAY);
    vecs[8]  = mk_vec(0, 1, 1, B_NONE,         0, D_UP, S_IDLE);
    vecs[9]  = mk_vec(0, 1, 1, B_UP | B_RIGHT, 1, D_UP, S_ACCEL);
    for (int i = 10; i < 17; i++)
      vecs[i] = mk_vec(0, 1, 1, B_UP | B_RIGHT, 1, D_UP, S_ACCEL);
    vecs[17] = mk_vec(0, 1, 1, B_UP | B_RIGHT, 2, D_UP, S_ACCEL);
    vecs[18] = mk_vec(0, 1, 0, B_NONE,         2, D_UP, S_DECAY);
    vecs[19] = mk_vec(0, 1, 0, B_UP,           2, D_UP, S_ACCEL);
    vecs[20] = mk_vec(1, 1, 0, B_NONE,         0, D_UP, S_IDLE);

    for (int i = 0; i < NVEC; i++)
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ga, vecs[i].tick, vecs[i].btn,
          vecs[i].lvl, vecs[i].dir, vecs[i].st);

    // Ramp to cruise with btn_right held, then hold through tick 100.
    cyc("ramp_start", 0, 1, 0, B_RIGHT, 1, D_RIGHT, S_ACCEL);
    for (int t = 1; t <= 100; t++) begin
      lvl = (1 + t / 8 > 6) ? 6 : 1 + t / 8;
      cyc($sformatf("ramp_tick%0d", t), 0, 1, 1, B_RIGHT, lvl, D_RIGHT,
          (lvl == 6) ? S_CRUISE : S_ACCEL);
      cyc($sformatf("ramp_gap%0d", t), 0, 1, 0, B_RIGHT, lvl, D_RIGHT,
          (lvl == 6) ? S_CRUISE : S_ACCEL);
    end

    // Decay from cruise after release.
    cyc("decay_start", 0, 1, 0, B_NONE, 6, D_RIGHT, S_DECAY);
    for (int t = 1; t <= 24; t++) begin
      lvl = 6 - t / 4;
      cyc($sformatf("decay_tick%0d", t), 0, 1, 1, B_NONE, lvl, D_RIGHT,
          (lvl == 0) ? S_IDLE : S_DECAY);
    end

    // Reversal from level 3 heading right.
    cyc("rev_start", 0, 1, 0, B_RIGHT, 1, D_RIGHT, S_ACCEL);
    for (int t = 1; t <= 16; t++)
      cyc($sformatf("rev_ramp%0d", t), 0, 1, 1, B_RIGHT, 1 + t / 8, D_RIGHT, S_ACCEL);
    cyc("brake_enter", 0, 1, 0, B_LEFT, 3, D_RIGHT, S_BRAKE);
    cyc("brake_tick1", 0, 1, 1, B_LEFT, 2, D_RIGHT, S_BRAKE);
    cyc("brake_tick2", 0, 1, 1, B_LEFT, 1, D_RIGHT, S_BRAKE);
    cyc("brake_tick3", 0, 1, 1, B_LEFT, 0, D_LEFT, S_ACCEL);
    cyc("turn_wait",   0, 1, 0, B_LEFT, 0, D_LEFT, S_ACCEL);
    cyc("turn_tick",   0, 1, 1, B_LEFT, 1, D_LEFT, S_ACCEL);

    // Climb to level 4 heading left, then freeze and re-enable with btn_down.
    for (int t = 1; t <= 24; t++)
      cyc($sformatf("left_ramp%0d", t), 0, 1, 1, B_LEFT, 1 + t / 8, D_LEFT, S_ACCEL);
    cyc("freeze1",  0, 0, 0, B_LEFT, 0, D_LEFT, S_FROZEN);
    cyc("freeze2",  0, 0, 1, B_LEFT, 0, D_LEFT, S_FROZEN);
    cyc("unfreeze", 0, 1, 0, B_DOWN, 0, D_LEFT, S_IDLE);
    cyc("restart",  0, 1, 0, B_DOWN, 1, D_DOWN, S_ACCEL);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
